layer_sequencer: RTL and testbench

- Top-level sequencer for the systolic MAC array: accepts one layer command per valid/ready handshake and runs the full layer on the existing control blocks.
- Per layer: clear the accumulators, load weights through the weight pipeline controller, then run one or more compute passes through the valid-pipeline or layering controller.
- Captures the per-lane accumulator results and presents them on a valid/ready result port.
- Drives the start/mode/clear inputs currently exposed at the system boundary, replacing manual strobing.

---
 rtl/layer_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer sequencer for the systolic MAC array.
// Accepts one layer command per valid/ready handshake, then clears the
// accumulators, loads weights, runs one or more compute passes and returns
// the per-lane accumulator captures on a valid/ready result port.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cmd_*                    layer command (mode, layering select, pass count)
//   start_weight, mode       weight pipeline controller start pulse / held mode
//   start_valid_pipeline,    compute controller start pulses
//   start_layering
//   clear_all                accumulator clear pulse
//   weight_busy,             controller busy inputs
//   compute_busy
//   valid_out, acc_in        MAC array per-lane valid and accumulators
//   res_*                    captured result, lane mask and timeout flag
//   idle                     sequencer waiting for a command
module layer_sequencer #(
  parameter int unsigned N_MACS    = 4,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_mode,
  input  logic                      cmd_layering,
  input  logic [3:0]                cmd_passes,
  output logic                      start_weight,
  output logic [2:0]                mode,
  output logic                      start_valid_pipeline,
  output logic                      start_layering,
  output logic                      clear_all,
  input  logic                      weight_busy,
  input  logic                      compute_busy,
  input  logic [N_MACS-1:0]         valid_out,
  input  logic [N_MACS*ACC_W-1:0]   acc_in,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [N_MACS*ACC_W-1:0]   res_data,
  output logic [N_MACS-1:0]         res_lane_mask,
  output logic                      res_timeout,
  output logic                      idle
);

  localparam int unsigned DATA_W = N_MACS * ACC_W;
  // Last watchdog value before expiry; the transition taken here lands in
  // RESULT exactly 2^TIMEOUT_W-1 cycles after entering the wait state.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_WAIT_W,
    S_START_C,
    S_WAIT_C,
    S_RESULT
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic                  layering_q, layering_d;
  logic [3:0]            passes_q, passes_d;
  logic [3:0]            pass_cnt_q, pass_cnt_d;
  logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
  logic [DATA_W-1:0]     res_data_q, res_data_d;
  logic [N_MACS-1:0]     mask_q, mask_d;
  logic                  timeout_q, timeout_d;
  logic                  clear_q, clear_d;
  logic                  start_w_q, start_w_d;
  logic                  start_vp_q, start_vp_d;
  logic                  start_lay_q, start_lay_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_W-1:0]     cap_data;

  // Per-lane capture: take the accumulator of every lane flagging valid.
  for (genvar g = 0; g < N_MACS; g++) begin : g_lane
    assign cap_data[g*ACC_W +: ACC_W] = valid_out[g] ? acc_in[g*ACC_W +: ACC_W]
                                                     : res_data_q[g*ACC_W +: ACC_W];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    layering_d  = layering_q;
    passes_d    = passes_q;
    pass_cnt_d  = pass_cnt_q;
    wdog_d      = wdog_q;
    res_data_d  = res_data_q;
    mask_d      = mask_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d     = cmd_mode;
          layering_d = cmd_layering;
          passes_d   = (cmd_passes == 4'd0) ? 4'd1 : cmd_passes;
          pass_cnt_d = 4'd0;
          mask_d     = '0;
          timeout_d  = 1'b0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_LOAD_W;
      S_LOAD_W: begin
        wdog_d  = '0;
        state_d = S_WAIT_W;
      end
      S_WAIT_W: begin
        // wdog_q == 0 marks the grace cycle where busy is not yet valid.
        if ((wdog_q != '0) && !weight_busy) begin
          state_d = S_START_C;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_RESULT;
        end else begin
          wdog_d = wdog_q + TIMEOUT_W'(1);
        end
      end
      S_START_C: begin
        wdog_d  = '0;
        state_d = S_WAIT_C;
      end
      S_WAIT_C: begin
        res_data_d = cap_data;
        mask_d     = mask_q | valid_out;
        if ((wdog_q != '0) && !compute_busy) begin
          if (pass_cnt_q < (passes_q - 4'd1)) begin
            pass_cnt_d = pass_cnt_q + 4'd1;
            state_d    = S_START_C;
          end else begin
            state_d = S_RESULT;
          end
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_RESULT;
        end else begin
          wdog_d = wdog_q + TIMEOUT_W'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pulses and res_valid track the state being entered so they line up
    // with that state's single cycle.
    clear_d     = (state_d == S_CLEAR);
    start_w_d   = (state_d == S_LOAD_W);
    start_lay_d = (state_d == S_START_C) && layering_d;
    start_vp_d  = (state_d == S_START_C) && !layering_d;
    res_valid_d = (state_d == S_RESULT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 3'd0;
      layering_q  <= 1'b0;
      passes_q    <= 4'd0;
      pass_cnt_q  <= 4'd0;
      wdog_q      <= '0;
      res_data_q  <= '0;
      mask_q      <= '0;
      timeout_q   <= 1'b0;
      clear_q     <= 1'b0;
      start_w_q   <= 1'b0;
      start_vp_q  <= 1'b0;
      start_lay_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      layering_q  <= layering_d;
      passes_q    <= passes_d;
      pass_cnt_q  <= pass_cnt_d;
      wdog_q      <= wdog_d;
      res_data_q  <= res_data_d;
      mask_q      <= mask_d;
      timeout_q   <= timeout_d;
      clear_q     <= clear_d;
      start_w_q   <= start_w_d;
      start_vp_q  <= start_vp_d;
      start_lay_q <= start_lay_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cmd_ready            = (state_q == S_IDLE);
  assign idle                 = (state_q == S_IDLE);
  assign mode                 = mode_q;
  assign clear_all            = clear_q;
  assign start_weight         = start_w_q;
  assign start_valid_pipeline = start_vp_q;
  assign start_layering       = start_lay_q;
  assign res_valid            = res_valid_q;
  assign res_data             = res_data_q;
  assign res_lane_mask        = mask_q;
  assign res_timeout          = timeout_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: emulates the weight/compute
// controllers and the MAC array, and predicts results from the command
// and the lane values it drives.
module tb_layer_sequencer;

  localparam int unsigned N_MACS    = 4;
  localparam int unsigned ACC_W     = 16;
  localparam int unsigned TIMEOUT_W = 4;
  localparam int unsigned DATA_W    = N_MACS * ACC_W;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [2:0]          cmd_mode = 3'd0;
  logic                cmd_layering = 1'b0;
  logic [3:0]          cmd_passes = 4'd0;
  logic                start_weight;
  logic [2:0]          mode;
  logic                start_valid_pipeline;
  logic                start_layering;
  logic                clear_all;
  logic                weight_busy;
  logic                compute_busy;
  logic [N_MACS-1:0]   valid_out;
  logic [DATA_W-1:0]   acc_in;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [DATA_W-1:0]   res_data;
  logic [N_MACS-1:0]   res_lane_mask;
  logic                res_timeout;
  logic                idle;

  layer_sequencer #(.N_MACS(N_MACS), .ACC_W(ACC_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_layering(cmd_layering), .cmd_passes(cmd_passes),
    .start_weight(start_weight), .mode(mode),
    .start_valid_pipeline(start_valid_pipeline), .start_layering(start_layering),
    .clear_all(clear_all), .weight_busy(weight_busy), .compute_busy(compute_busy),
    .valid_out(valid_out), .acc_in(acc_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_lane_mask(res_lane_mask), .res_timeout(res_timeout), .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] exp_data = '0;
  logic [N_MACS-1:0] exp_mask = '0;
  logic [2:0]        exp_mode = 3'd0;
  int  wlen = 3, clen_fix = -1, clen_cur = 0;
  bit  wstuck = 0, cstuck = 0, fixed_pat = 0;
  int  kw = -1, kc = -1;
  int  n_clr = 0, n_w = 0, n_vp = 0, n_lay = 0, mode_err = 0;
  int  c_clr = -1, c_w = -1, c_c = -1;

  // Controller / MAC-array emulation. Busy windows are relative to the start
  // pulse; the sequencer's capture window for a pass runs from the cycle after
  // the start pulse up to and including the first post-grace cycle with busy low.
  initial begin : responder
    int last;
    logic [ACC_W-1:0] lane;
    logic [ACC_W-1:0] cur;
    logic v;
    weight_busy = 1'b0; compute_busy = 1'b0; valid_out = '0; acc_in = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        kw = -1; kc = -1;
        weight_busy = 1'b0; compute_busy = 1'b0; valid_out = '0; acc_in = '0;
      end else begin
        if (clear_all) begin n_clr++; c_clr = cyc; end
        if (start_weight) begin n_w++; c_w = cyc; kw = 0; end
        else if (kw >= 0) kw++;
        if (start_valid_pipeline) n_vp++;
        if (start_layering) n_lay++;
        if (start_valid_pipeline || start_layering) begin
          c_c = cyc; kc = 0;
          clen_cur = (clen_fix >= 0) ? clen_fix : int'($urandom_range(0, 8));
        end else if (kc >= 0) kc++;
        if (!idle && mode !== exp_mode) mode_err++;

        weight_busy  = (kw >= 1) && (wstuck || kw <= wlen);
        compute_busy = 1'b0; valid_out = '0; acc_in = '0;
        if (res_valid || kc == 0) begin
          // Outside any capture window: must never be captured.
          valid_out = '1; acc_in = '1;
        end else if (kc >= 1) begin
          last = cstuck ? 5 : ((clen_cur == 0) ? 2 : clen_cur + 1);
          compute_busy = cstuck || (kc <= clen_cur);
          if (kc <= last) begin
            for (int i = 0; i < int'(N_MACS); i++) begin
              lane = fixed_pat ? ACC_W'(10 * (i + 1)) : ACC_W'($urandom);
              v    = fixed_pat ? 1'b1 : 1'($urandom);
              cur  = exp_data[ACC_W-1:0];
              acc_in    = {lane, acc_in[DATA_W-1:ACC_W]};
              valid_out = {v, valid_out[N_MACS-1:1]};
              exp_data  = {(v ? lane : cur), exp_data[DATA_W-1:ACC_W]};
              exp_mask  = {exp_mask[0] | v, exp_mask[N_MACS-1:1]};
            end
          end
        end
      end
    end
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

  task automatic clr_counts();
    n_clr = 0; n_w = 0; n_vp = 0; n_lay = 0; mode_err = 0;
    c_clr = -1; c_w = -1; c_c = -1;
  endtask

  task automatic send_cmd(input logic [2:0] m, input logic lay, input logic [3:0] p,
                          output bit ok);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mode = m; cmd_layering = lay; cmd_passes = p;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    ok = cmd_ready;
    exp_mode = m; exp_mask = '0;
    clr_counts();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(output bit ok, output int rcyc);
    int n;
    n = 0;
    while (!res_valid && n < 400) begin @(negedge clk); n++; end
    ok = res_valid; rcyc = cyc;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({idle, cmd_ready, res_valid, clear_all, start_weight, start_valid_pipeline,
         start_layering, res_timeout} !== 8'b1100_0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 11000000",
               {idle, cmd_ready, res_valid, clear_all, start_weight,
                start_valid_pipeline, start_layering, res_timeout});
    end
    checks++;
    if (mode !== 3'd0 || res_data !== '0 || res_lane_mask !== '0) begin
      failures++;
      $display("FAIL reset_regs: mode=%0d data=%h mask=%h expected zeros",
               mode, res_data, res_lane_mask);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_layer();
    bit ok; int rc;
    wlen = 5; clen_fix = 8; fixed_pat = 1;
    send_cmd(3'd3, 1'b0, 4'd1, ok);
    wait_result(ok, rc);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_wait: no res_valid"); end
    checks++;
    if (res_data !== {16'd40, 16'd30, 16'd20, 16'd10} || res_data !== exp_data) begin
      failures++;
      $display("FAIL single_data: got %h expected %h", res_data,
               {16'd40, 16'd30, 16'd20, 16'd10});
    end
    checks++;
    if (res_lane_mask !== 4'hF || res_timeout !== 1'b0) begin
      failures++;
      $display("FAIL single_mask: mask=%h to=%b expected f/0", res_lane_mask, res_timeout);
    end
    checks++;
    if (n_clr != 1 || n_w != 1 || n_vp != 1 || n_lay != 0) begin
      failures++;
      $display("FAIL single_pulses: clr=%0d w=%0d vp=%0d lay=%0d expected 1/1/1/0",
               n_clr, n_w, n_vp, n_lay);
    end
    checks++;
    if (c_w != c_clr + 1 || c_c != c_w + 7) begin
      failures++;
      $display("FAIL single_order: clr@%0d w@%0d c@%0d expected w=clr+1 c=w+7",
               c_clr, c_w, c_c);
    end
    checks++;
    if (mode_err != 0 || mode !== 3'd3) begin
      failures++;
      $display("FAIL single_mode: errors=%0d mode=%0d expected 0 errors, mode 3",
               mode_err, mode);
    end
    handshake();
    checks++;
    if (res_valid !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL single_release: res_valid=%b idle=%b expected 0/1", res_valid, idle);
    end
    fixed_pat = 0; clen_fix = -1;
  endtask

  task automatic test_layering_passes();
    bit ok; int rc;
    wlen = int'($urandom_range(0, 6));
    send_cmd(3'(($urandom)), 1'b1, 4'd3, ok);
    wait_result(ok, rc);
    checks++;
    if (!ok || n_lay != 3 || n_vp != 0 || n_clr != 1 || n_w != 1) begin
      failures++;
      $display("FAIL lay3_pulses: ok=%0d lay=%0d vp=%0d clr=%0d w=%0d expected 1/3/0/1/1",
               ok, n_lay, n_vp, n_clr, n_w);
    end
    checks++;
    if (res_data !== exp_data || res_lane_mask !== exp_mask || res_timeout !== 1'b0) begin
      failures++;
      $display("FAIL lay3_data: got %h/%h/%b expected %h/%h/0",
               res_data, res_lane_mask, res_timeout, exp_data, exp_mask);
    end
    handshake();
  endtask

  task automatic test_passes_zero();
    bit ok; int rc;
    wlen = 2;
    send_cmd(3'd5, 1'($urandom), 4'd0, ok);
    wait_result(ok, rc);
    checks++;
    if (!ok || (n_vp + n_lay) != 1) begin
      failures++;
      $display("FAIL passes0: ok=%0d compute_pulses=%0d expected 1", ok, n_vp + n_lay);
    end
    checks++;
    if (res_data !== exp_data || res_lane_mask !== exp_mask) begin
      failures++;
      $display("FAIL passes0_data: got %h/%h expected %h/%h",
               res_data, res_lane_mask, exp_data, exp_mask);
    end
    handshake();
  endtask

  task automatic test_random_layers();
    bit ok; int rc; logic [3:0] p; logic lay; int np; int exp_cc;
    for (int t = 0; t < 6; t++) begin
      wlen = int'($urandom_range(0, 9));
      p = 4'($urandom_range(0, 3));
      lay = 1'($urandom);
      np = (p == 4'd0) ? 1 : int'(p);
      send_cmd(3'($urandom), lay, p, ok);
      wait_result(ok, rc);
      exp_cc = c_w + ((wlen == 0) ? 1 : wlen) + 2;
      checks++;
      if (!ok || n_lay != (lay ? np : 0) || n_vp != (lay ? 0 : np) || n_clr != 1 || n_w != 1) begin
        failures++;
        $display("FAIL rand%0d_pulses: lay=%0d vp=%0d clr=%0d w=%0d passes=%0d layering=%b",
                 t, n_lay, n_vp, n_clr, n_w, np, lay);
      end
      checks++;
      if (res_data !== exp_data || res_lane_mask !== exp_mask || res_timeout !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_data: got %h/%h/%b expected %h/%h/0",
                 t, res_data, res_lane_mask, res_timeout, exp_data, exp_mask);
      end
      checks++;
      if (mode_err != 0 || c_w != c_clr + 1) begin
        failures++;
        $display("FAIL rand%0d_seq: mode_err=%0d clr@%0d w@%0d expected 0, w=clr+1",
                 t, mode_err, c_clr, c_w);
      end
      if (np == 1) begin
        checks++;
        if (c_c != exp_cc) begin
          failures++;
          $display("FAIL rand%0d_latency: compute start@%0d expected %0d", t, c_c, exp_cc);
        end
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int rc; int viol; logic [DATA_W-1:0] snap;
    wlen = 3;
    send_cmd(3'd6, 1'b0, 4'd2, ok);
    wait_result(ok, rc);
    snap = exp_data;
    // Second command held by the producer while the result is stalled.
    cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_layering = 1'b1; cmd_passes = 4'd1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b1 || res_data !== snap || cmd_ready !== 1'b0) viol++;
      @(negedge clk);
    end
    checks++;
    if (!ok || viol != 0) begin
      failures++;
      $display("FAIL bp_stable: ok=%0d violations=%0d expected 1/0", ok, viol);
    end
    checks++;
    if (res_data !== exp_data || res_lane_mask !== exp_mask) begin
      failures++;
      $display("FAIL bp_data: got %h/%h expected %h/%h",
               res_data, res_lane_mask, exp_data, exp_mask);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_mode = 3'd1; exp_mask = '0;
    clr_counts();
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: res_valid=%b cmd_ready=%b expected 0/1", res_valid, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (clear_all !== 1'b1 || mode !== 3'd1) begin
      failures++;
      $display("FAIL bp_accept: clear_all=%b mode=%0d expected 1/1", clear_all, mode);
    end
    wait_result(ok, rc);
    checks++;
    if (!ok || res_data !== exp_data || res_lane_mask !== exp_mask || n_lay != 1) begin
      failures++;
      $display("FAIL bp_second: got %h/%h lay=%0d expected %h/%h/1",
               res_data, res_lane_mask, n_lay, exp_data, exp_mask);
    end
    handshake();
  endtask

  task automatic test_watchdog();
    bit ok; int rc;
    // Weight controller never drops busy.
    wstuck = 1;
    send_cmd(3'd2, 1'b0, 4'd1, ok);
    wait_result(ok, rc);
    checks++;
    if (!ok || rc != c_w + 16) begin
      failures++;
      $display("FAIL wd_weight_time: result@%0d expected %0d", rc, c_w + 16);
    end
    checks++;
    if (res_timeout !== 1'b1 || res_lane_mask !== 4'h0 || (n_vp + n_lay) != 0) begin
      failures++;
      $display("FAIL wd_weight_state: to=%b mask=%h compute_pulses=%0d expected 1/0/0",
               res_timeout, res_lane_mask, n_vp + n_lay);
    end
    wstuck = 0;
    handshake();

    // Busy drops on the last watchdog cycle: normal exit wins.
    wlen = 14;
    send_cmd(3'd4, 1'b1, 4'd1, ok);
    wait_result(ok, rc);
    checks++;
    if (!ok || res_timeout !== 1'b0 || n_lay != 1 || c_c != c_w + 16) begin
      failures++;
      $display("FAIL wd_boundary: to=%b lay=%0d start@%0d expected 0/1/%0d",
               res_timeout, n_lay, c_c, c_w + 16);
    end
    handshake();

    // Compute controller never drops busy: partial capture kept.
    wlen = 1; cstuck = 1;
    send_cmd(3'd7, 1'b0, 4'd2, ok);
    wait_result(ok, rc);
    checks++;
    if (!ok || rc != c_c + 16 || res_timeout !== 1'b1 || n_vp != 1) begin
      failures++;
      $display("FAIL wd_compute: result@%0d to=%b vp=%0d expected %0d/1/1",
               rc, res_timeout, n_vp, c_c + 16);
    end
    checks++;
    if (res_data !== exp_data || res_lane_mask !== exp_mask) begin
      failures++;
      $display("FAIL wd_compute_data: got %h/%h expected %h/%h",
               res_data, res_lane_mask, exp_data, exp_mask);
    end
    cstuck = 0;
    handshake();
  endtask

  task automatic test_reset_mid_layer();
    bit ok; int n; int seen;
    wlen = 2; clen_fix = 8;
    send_cmd(3'd5, 1'b0, 4'd1, ok);
    n = 0;
    while ((n_vp + n_lay) == 0 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({idle, cmd_ready, res_valid, clear_all, start_weight, start_valid_pipeline,
         start_layering, res_timeout} !== 8'b1100_0000 || mode !== 3'd0 ||
        res_data !== '0 || res_lane_mask !== '0) begin
      failures++;
      $display("FAIL rst_mid: flags=%b mode=%0d data=%h mask=%h expected 11000000/0/0/0",
               {idle, cmd_ready, res_valid, clear_all, start_weight,
                start_valid_pipeline, start_layering, res_timeout},
               mode, res_data, res_lane_mask);
    end
    exp_data = '0; exp_mask = '0; clen_fix = -1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release: idle=%b cmd_ready=%b expected 1/1", idle, cmd_ready);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_no_result: res_valid cycles=%0d expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_layering_passes();
    test_passes_zero();
    test_random_layers();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_layer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
